// File: rtl/reg_dump_tx_pkg.sv
// Shared constants for the HC4 register dump path: data width and
// counter sizing helper used by the serialiser and its pacing divider.
package reg_dump_tx_pkg;

   localparam int HC4_DATA_WIDTH = 4;

   // Counter width that can hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_dump_tx_tick_divider.sv
// Phase pacer for the serialiser: tick is high on every CLKDIV-th cycle
// counted from the last clear, and the count restarts after each tick.
module tick_divider
   import reg_dump_tx_pkg::*;
#(
   parameter int CLKDIV = 2
) (
   input  logic clk,
   input  logic nReset,
   input  logic clear,
   output logic tick
);

   localparam int DW = cnt_width(CLKDIV);

   logic [DW-1:0] divcnt;

   assign tick = (divcnt == DW'(CLKDIV - 1));

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         divcnt <= '0;
      end else if (clear || tick) begin
         divcnt <= '0;
      end else begin
         divcnt <= divcnt + 1'b1;
      end
   end

endmodule

// File: rtl/reg_dump_tx.sv
// Snapshots the register bank and shifts it out MSB first on sdata/sclk,
// finishing each frame with one rclk strobe for the 74HC595 display chain.
module reg_dump_tx
   import reg_dump_tx_pkg::*;
#(
   parameter int WIDTH  = HC4_DATA_WIDTH,
   parameter int NREGS  = 4,
   parameter int CLKDIV = 2
) (
   input  logic                   clk,
   input  logic                   nReset,
   input  logic                   nStart,
   input  logic [NREGS*WIDTH-1:0] regs,
   output logic                   busy,
   output logic                   sdata,
   output logic                   sclk,
   output logic                   rclk
);

   localparam int NBITS = NREGS * WIDTH;
   localparam int BW    = cnt_width(NBITS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] HIGH  = 2'd2;
   localparam logic [1:0] LATCH = 2'd3;

   logic [1:0]       state;
   logic [NBITS-1:0] shadow;
   logic [NBITS-1:0] shifted;
   logic [BW-1:0]    bitcnt;
   logic             tick;
   logic             clear;

   // Holding the divider clear in IDLE makes every frame start from a fresh phase.
   assign clear   = (state == IDLE);
   assign shifted = shadow << 1;

   tick_divider #(
      .CLKDIV (CLKDIV)
   ) u_div (
      .clk    (clk),
      .nReset (nReset),
      .clear  (clear),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state  <= IDLE;
         shadow <= '0;
         bitcnt <= '0;
         busy   <= 1'b0;
         sdata  <= 1'b0;
         sclk   <= 1'b0;
         rclk   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!nStart) begin
                  shadow <= regs;
                  bitcnt <= BW'(NBITS - 1);
                  busy   <= 1'b1;
                  sdata  <= regs[NBITS-1];
                  state  <= SETUP;
               end
            end
            SETUP: begin
               if (tick) begin
                  sclk  <= 1'b1;
                  state <= HIGH;
               end
            end
            HIGH: begin
               if (tick) begin
                  sclk <= 1'b0;
                  if (bitcnt == '0) begin
                     sdata <= 1'b0;
                     rclk  <= 1'b1;
                     state <= LATCH;
                  end else begin
                     // Next bit goes straight to the pin so it sits stable for the whole SETUP phase.
                     shadow <= shifted;
                     sdata  <= shifted[NBITS-1];
                     bitcnt <= bitcnt - 1'b1;
                     state  <= SETUP;
                  end
               end
            end
            LATCH: begin
               if (tick) begin
                  rclk  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
